addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined integer adder/subtractor for the MIPS 32-bit datapath. The WIDTH-bit operation is split into STAGES equal carry segments, each registered, so long carry chains do not limit clock frequency. It accepts one operation per cycle through a valid/ready handshake and produces sum, carry-out, signed overflow and zero flags for the ALU and branch-compare paths.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 4, number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  00 ADD (A+B), 01 ADDC (A+B+cin), 10 SUB (A−B), 11 SUBB (A+~B+cin)
- cin  input  1  carry-in, used only for ADDC/SUBB
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for SUB: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

## Operation
- Operand preparation at input: b_eff = op[1] ? ~b : b; c0 = op==00 ? 0 : op==10 ? 1 : cin.
- Transfer into stage 1 when in_valid && in_ready.
- Stage k (1..STAGES) computes segment k−1 (bits [k·SEG−1 : (k−1)·SEG]) from the carry registered by stage k−1 (c0 for stage 1); lower result segments are carried forward, upper operand segments are carried forward unmodified (skew registers).
- Each stage holds a valid bit; bubbles (in_valid=0) propagate as invalid entries.
- Final stage registers sum, cout = carry out of bit WIDTH−1, ovf = carry into MSB XOR carry out of MSB, zero = ~|sum.
- Stall: stall = out_valid && !out_ready. When stall=1 every stage holds (no register updates, including valid bits). in_ready = !stall.
- Output register holds sum/flags stable while out_valid && !out_ready.
- STAGES=1 degenerates to a single registered full-width adder with the same handshake.

## Timing
- Latency: exactly STAGES cycles from accepted input to out_valid, absent stalls; each stall cycle adds one.
- Throughput: one operation per cycle when out_ready held high.
- Reset: all valid bits 0; out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight entries; no partial result emerges.
- in_ready depends combinationally on out_ready (global-stall pipeline); no combinational path from in_valid to out_valid.
- Simultaneous out_ready=0 and new in_valid while stalled: input not accepted, upstream must hold.
- Output data outside out_valid is don't-care for checking but must not be X after reset.
- Wrap-around: sum is modulo 2^WIDTH; cout/ovf report the overflow, never saturate.

## Test plan
- Reset then ADD a=0x0000_0001, b=0xFFFF_FFFF, WIDTH=32, STAGES=4 -> after 4 cycles sum=0, cout=1, ovf=0, zero=1.
- ADD a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, cout=0, ovf=1; SUB a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- SUB a=3, b=5 -> sum=0xFFFF_FFFE, cout=0; SUBB a=5, b=3, cin=0 -> sum=1; ADDC a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1.
- Back-to-back 100 random ops with out_ready=1 -> one result per cycle, in order, matching golden model; then random out_ready/in_valid gating -> no drops or duplicates, outputs stable while stalled.
- Assert rst while 3 ops in flight -> out_valid=0 next cycle, no stale result emerges after reset releases.
- Re-run random suite with STAGES=1, 2, 8, 32 and WIDTH=16 -> latency equals STAGES, results match model.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined integer adder/subtractor: the WIDTH-bit carry chain is cut into STAGES
// registered segments, with a global-stall valid/ready handshake and sum/carry/overflow/zero flags.
module addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG = WIDTH / STAGES;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_ADDC = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_SUBB = 2'b11;

   logic             stall;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Stage k holds the operands (skewed), the result bits finished so far and
   // the carry out of segment k-1.
   logic [STAGES:1]  vld_q;
   logic [WIDTH-1:0] a_q [1:STAGES];
   logic [WIDTH-1:0] b_q [1:STAGES];
   logic [WIDTH-1:0] s_q [1:STAGES];
   logic [STAGES:1]  c_q;
   logic             ovf_q;
   logic             zero_q;

   logic [WIDTH-1:0] a_src [1:STAGES];
   logic [WIDTH-1:0] b_src [1:STAGES];
   logic [WIDTH-1:0] s_src [1:STAGES];
   logic [WIDTH-1:0] s_nxt [1:STAGES];
   logic [SEG:0]     seg_sum [1:STAGES];
   logic [STAGES:1]  c_src;
   logic [STAGES:1]  c_nxt;
   logic [STAGES:1]  v_src;
   logic             ovf_nxt;
   logic             zero_nxt;

   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      b_eff = op[1] ? ~b : b;
      c0    = cin;
      case (op)
         OP_ADD:  c0 = 1'b0;
         OP_SUB:  c0 = 1'b1;
         OP_ADDC: c0 = cin;
         OP_SUBB: c0 = cin;
         default: c0 = cin;
      endcase
   end

   // A stalled output freezes the whole pipeline, so ready is simply "not stalled".
   assign stall    = vld_q[STAGES] && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      a_src[1] = a;
      b_src[1] = b_eff;
      s_src[1] = '0;
      c_src[1] = c0;
      v_src[1] = accept;
      for (int k = 2; k <= STAGES; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = vld_q[k-1];
      end
      for (int k = 1; k <= STAGES; k++) begin
         seg_sum[k] = {1'b0, a_src[k][(k-1)*SEG +: SEG]}
                    + {1'b0, b_src[k][(k-1)*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_src[k]};
         s_nxt[k]                   = s_src[k];
         s_nxt[k][(k-1)*SEG +: SEG] = seg_sum[k][SEG-1:0];
         c_nxt[k]                   = seg_sum[k][SEG];
      end
   end

   // Carry into the MSB is recovered from the MSB's own sum bit.
   assign ovf_nxt  = a_src[STAGES][WIDTH-1] ^ b_src[STAGES][WIDTH-1]
                   ^ s_nxt[STAGES][WIDTH-1] ^ c_nxt[STAGES];
   assign zero_nxt = ~|s_nxt[STAGES];

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   // NOTE: data registers are reset too, so sum/flags are never X after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 1; k <= STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (!stall) begin
         vld_q <= v_src;
         for (int k = 1; k <= STAGES; k++) begin
            if (v_src[k]) begin
               a_q[k] <= a_src[k];
               b_q[k] <= b_src[k];
               s_q[k] <= s_nxt[k];
               c_q[k] <= c_nxt[k];
            end
         end
         if (v_src[STAGES]) begin
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
         end
      end
   end

   assign out_valid = vld_q[STAGES];
   assign sum       = s_q[STAGES];
   assign cout      = c_q[STAGES];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed corner cases, random back-to-back and
// gated-handshake traffic against an arithmetic reference model, reset flush, other geometries.
module tb_addsub_pipe;

   localparam int W = 32;
   localparam int S = 4;
   localparam int NA = 7;
   localparam int AW [NA] = '{32, 32, 32, 32, 16, 16, 16};
   localparam int AS [NA] = '{1, 2, 8, 32, 1, 8, 16};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, sum;
   logic [1:0]    op;
   logic          cin, cout, ovf, zero;

   logic          aux_in_valid;
   logic [31:0]   aux_a, aux_b;
   logic [1:0]    aux_op;
   logic          aux_cin;
   logic [NA-1:0] aux_ov, aux_ir, aux_cout, aux_ovf, aux_zero;
   logic [31:0]   aux_sum [NA];

   int n_tests = 0;
   int n_fail  = 0;
   int ncyc    = 0;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          t;
   } res_t;

   res_t main_q [$];
   res_t aq [NA][$];

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   for (genvar g = 0; g < NA; g++) begin : g_aux
      localparam int AWG = AW[g];
      logic [AWG-1:0] s;
      addsub_pipe #(.WIDTH(AWG), .STAGES(AS[g])) u_aux (
         .clk(clk), .rst(rst), .in_valid(aux_in_valid), .in_ready(aux_ir[g]),
         .a(aux_a[AWG-1:0]), .b(aux_b[AWG-1:0]), .op(aux_op), .cin(aux_cin),
         .out_valid(aux_ov[g]), .out_ready(1'b1),
         .sum(s), .cout(aux_cout[g]), .ovf(aux_ovf[g]), .zero(aux_zero[g])
      );
      assign aux_sum[g] = 32'(s);
   end

   // Reference: exact integer arithmetic, both unsigned (carry) and signed (overflow).
   function automatic res_t model(int w, logic [31:0] x, logic [31:0] y,
                                  logic [1:0] o, logic ci, int t);
      res_t   r;
      longint full = longint'(1) << w;
      longint m    = full - 1;
      longint half = full >> 1;
      longint ua   = longint'(x) & m;
      longint ub   = longint'(y) & m;
      longint c    = (o == 2'b00) ? 0 : (o == 2'b10) ? 1 : longint'(ci);
      longint sa   = (ua >= half) ? ua - full : ua;
      longint sb   = (ub >= half) ? ub - full : ub;
      longint u, sv;
      if (!o[1]) begin
         u  = ua + ub + c;
         sv = sa + sb + c;
      end else begin
         u  = ua + (m - ub) + c;
         sv = sa - sb - 1 + c;
      end
      r.sum  = 32'(u & m);
      r.cout = (u >= full);
      r.ovf  = (sv >= half) || (sv < -half);
      r.zero = ((u & m) == 0);
      r.t    = t;
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      ncyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = 2'b00; cin = 1'b0;
      aux_in_valid = 1'b0; aux_a = '0; aux_b = '0; aux_op = 2'b00; aux_cin = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_tests++;
      if ({out_valid, cout, ovf, zero} !== 4'b0000 || sum !== '0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b sum=%h cout=%b ovf=%b zero=%b, required all zero",
                  out_valid, sum, cout, ovf, zero);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
      out_ready = 1'b1;
   endtask

   typedef struct {
      logic [31:0] va, vb;
      logic [1:0]  vop;
      logic        vcin;
      logic [31:0] esum;
      logic        ecout, eovf, ezero;
   } vec_t;

   task automatic test_directed();
      vec_t v [6];
      int   lat;
      v[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      v[2] = '{32'h8000_0000, 32'h0000_0001, 2'b10, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      v[3] = '{32'h0000_0003, 32'h0000_0005, 2'b10, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      v[4] = '{32'h0000_0005, 32'h0000_0003, 2'b11, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
      v[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         a = v[i].va; b = v[i].vb; op = v[i].vop; cin = v[i].vcin; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
         end
         n_tests++;
         if (lat != S) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, lat, S);
         end
         n_tests++;
         if (sum !== v[i].esum || cout !== v[i].ecout || ovf !== v[i].eovf || zero !== v[i].ezero) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
                     i, sum, cout, ovf, zero, v[i].esum, v[i].ecout, v[i].eovf, v[i].ezero);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_single[%0d]: out_valid=%b after result, required 0", i, out_valid);
         end
      end
   endtask

   task automatic run_main(string name, int n, bit gate);
      int          sent = 0;
      int          guard = 0;
      bit          pend = 1'b0;
      bit          prev_stall = 1'b0;
      logic [31:0] prev_sum = '0;
      logic [2:0]  prev_f = '0;
      res_t        r;
      main_q.delete();
      while ((sent < n || main_q.size() > 0) && guard < n * 20 + 100) begin
         tick();
         guard++;
         if (prev_stall) begin
            n_tests++;
            if (out_valid !== 1'b1 || sum !== prev_sum || {cout, ovf, zero} !== prev_f) begin
               n_fail++;
               $display("FAIL %s_hold: valid=%b sum=%h flags=%b, required valid=1 sum=%h flags=%b",
                        name, out_valid, sum, {cout, ovf, zero}, prev_sum, prev_f);
            end
         end
         if (!pend) begin
            in_valid = (sent < n) && (!gate || $urandom_range(0, 3) != 0);
            if (in_valid) begin
               a = rand_word(); b = rand_word();
               op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
            end
         end
         out_ready = gate ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         n_tests++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b with out_valid=%b out_ready=%b",
                     name, in_ready, out_valid, out_ready);
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (main_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra: result sum=%h with nothing outstanding", name, sum);
            end else begin
               r = main_q.pop_front();
               if (sum !== r.sum || cout !== r.cout || ovf !== r.ovf || zero !== r.zero) begin
                  n_fail++;
                  $display("FAIL %s_result: sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
                           name, sum, cout, ovf, zero, r.sum, r.cout, r.ovf, r.zero);
               end
               if (!gate) begin
                  n_tests++;
                  if (ncyc - r.t != S) begin
                     n_fail++;
                     $display("FAIL %s_latency: %0d cycles, required %0d", name, ncyc - r.t, S);
                  end
               end
            end
         end
         if (in_valid && in_ready) begin
            main_q.push_back(model(W, a, b, op, cin, ncyc));
            sent++;
            pend = 1'b0;
         end else begin
            pend = in_valid;
         end
         prev_stall = out_valid && !out_ready;
         prev_sum   = sum;
         prev_f     = {cout, ovf, zero};
      end
      n_tests++;
      if (sent != n || main_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: sent %0d of %0d, %0d results missing", name, sent, n, main_q.size());
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      run_main("b2b", 100, 1'b0);
   endtask

   task automatic test_gated();
      run_main("gated", 150, 1'b1);
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         a = rand_word(); b = rand_word(); op = 2'b00; cin = 1'b0; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || sum !== '0) begin
         n_fail++;
         $display("FAIL midflight_reset: out_valid=%b sum=%h, required 0 and 0", out_valid, sum);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_stale: out_valid=%b %0d cycles after reset, required 0", out_valid, i);
         end
      end
   endtask

   task automatic test_configs();
      res_t r;
      int   n = 60;
      for (int g = 0; g < NA; g++) aq[g].delete();
      for (int c = 0; c < n + 40; c++) begin
         tick();
         for (int g = 0; g < NA; g++) begin
            if (aux_ov[g] === 1'b1) begin
               n_tests++;
               if (aq[g].size() == 0) begin
                  n_fail++;
                  $display("FAIL cfg%0d_extra: W=%0d S=%0d result with nothing outstanding", g, AW[g], AS[g]);
               end else begin
                  r = aq[g].pop_front();
                  if (aux_sum[g] !== r.sum || aux_cout[g] !== r.cout ||
                      aux_ovf[g] !== r.ovf || aux_zero[g] !== r.zero) begin
                     n_fail++;
                     $display("FAIL cfg%0d_result: W=%0d S=%0d sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
                              g, AW[g], AS[g], aux_sum[g], aux_cout[g], aux_ovf[g], aux_zero[g],
                              r.sum, r.cout, r.ovf, r.zero);
                  end
                  n_tests++;
                  if (ncyc - r.t != AS[g]) begin
                     n_fail++;
                     $display("FAIL cfg%0d_latency: %0d cycles, required %0d", g, ncyc - r.t, AS[g]);
                  end
               end
            end
         end
         aux_in_valid = (c < n);
         if (aux_in_valid) begin
            aux_a = rand_word(); aux_b = rand_word();
            aux_op = 2'($urandom_range(0, 3)); aux_cin = 1'($urandom_range(0, 1));
            for (int g = 0; g < NA; g++) aq[g].push_back(model(AW[g], aux_a, aux_b, aux_op, aux_cin, ncyc));
         end
      end
      for (int g = 0; g < NA; g++) begin
         n_tests++;
         if (aq[g].size() != 0) begin
            n_fail++;
            $display("FAIL cfg%0d_drain: %0d results missing", g, aq[g].size());
         end
      end
      aux_in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_gated();
      test_reset_midflight();
      test_configs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
